// File: rtl/seg7_scan_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seg7_scan_reader: samples a 4-digit scanned 7-segment display, debounces    |
// | scan transitions, decodes each digit and presents a 16-bit frame.           |
// | Optional: SEG7_BLANK_EN (seg = 00 captures as a legal blank digit).         |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module seg7_scan_reader #(
   parameter int STABLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [6:0]  seg,
   input  logic [3:0]  an,
   output logic [15:0] out_value,
   output logic [3:0]  out_err,
   output logic [3:0]  out_blank,
   output logic        out_valid,
   input  logic        out_ready
);

   localparam logic [3:0] c_stable = 4'(STABLE_CYCLES);

   typedef enum logic [0:0] {
      COLLECT = 1'b0,
      PRESENT = 1'b1
   } state_t;

   state_t      r_state;
   state_t      w_state_next;
   logic [10:0] r_sample;
   logic [3:0]  r_cnt;
   logic [3:0]  r_mask;
   logic [15:0] r_value;
   logic [3:0]  r_err;

   logic [10:0] w_sample;
   logic        w_onehot;
   logic        w_changed;
   logic [3:0]  w_cnt_next;
   logic        w_capture;
   logic        w_write;
   logic        w_mask_clr;
   logic [1:0]  w_idx;
   logic [3:0]  w_nib;
   logic        w_illegal;
`ifdef SEG7_BLANK_EN
   logic        w_is_blank;
   logic [3:0]  r_blank;
`endif

   assign w_sample  = {an, seg};
   assign w_onehot  = $onehot(an);
   assign w_changed = (w_sample != r_sample);
   assign w_cnt_next = (w_changed || !w_onehot) ? 4'd1 :
                       (r_cnt == 4'hF)          ? 4'hF : r_cnt + 4'd1;
   // The second term keeps a saturated counter from recapturing when STABLE_CYCLES = 15.
   assign w_capture = w_onehot && (w_cnt_next == c_stable) &&
                      (w_changed || (r_cnt != c_stable));

   always_comb begin
      w_idx = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (an[i]) w_idx = 2'(i);
      end
   end

   always_comb begin
      w_nib     = 4'h0;
      w_illegal = 1'b0;
`ifdef SEG7_BLANK_EN
      w_is_blank = 1'b0;
`endif
      case (seg)
         7'h7E: w_nib = 4'h0;
         7'h06: w_nib = 4'h1;
         7'h5B: w_nib = 4'h2;
         7'h4F: w_nib = 4'h3;
         7'h27: w_nib = 4'h4;
         7'h6D: w_nib = 4'h5;
         7'h7D: w_nib = 4'h6;
         7'h46: w_nib = 4'h7;
         7'h7F: w_nib = 4'h8;
         7'h6F: w_nib = 4'h9;
         7'h77: w_nib = 4'hA;
         7'h3D: w_nib = 4'hB;
         7'h78: w_nib = 4'hC;
         7'h1F: w_nib = 4'hD;
         7'h79: w_nib = 4'hE;
         7'h71: w_nib = 4'hF;
`ifdef SEG7_BLANK_EN
         7'h00: w_is_blank = 1'b1;
`endif
         default: w_illegal = 1'b1;
      endcase
   end

   always_comb begin
      w_state_next = r_state;
      w_write      = 1'b0;
      w_mask_clr   = 1'b0;
      case (r_state)
         COLLECT: begin
            w_write = w_capture;
            if (r_mask == 4'hF) w_state_next = PRESENT;
         end
         PRESENT: begin
            // Captures are dropped here, including one coinciding with the handshake.
            if (out_ready) begin
               w_state_next = COLLECT;
               w_mask_clr   = 1'b1;
            end
         end
         default: w_state_next = COLLECT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= COLLECT;
         r_sample <= 11'd0;
         r_cnt    <= 4'd0;
         r_mask   <= 4'd0;
         r_value  <= 16'd0;
         r_err    <= 4'd0;
`ifdef SEG7_BLANK_EN
         r_blank  <= 4'd0;
`endif
      end else begin
         r_state  <= w_state_next;
         r_sample <= w_sample;
         r_cnt    <= w_cnt_next;
         if (w_mask_clr) begin
            r_mask <= 4'd0;
         end else if (w_write) begin
            r_mask[w_idx]                  <= 1'b1;
            r_value[{w_idx, 2'b00} +: 4]   <= w_nib;
            r_err[w_idx]                   <= w_illegal;
`ifdef SEG7_BLANK_EN
            r_blank[w_idx]                 <= w_is_blank;
`endif
         end
      end
   end

   assign out_value = r_value;
   assign out_err   = r_err;
   assign out_valid = (r_state == PRESENT);
`ifdef SEG7_BLANK_EN
   assign out_blank = r_blank;
`else
   assign out_blank = 4'b0000;
`endif

endmodule
`default_nettype wire

// File: doc/seg7_scan_reader.md
# seg7_scan_reader

Receive-side counterpart of the hex-to-segment display encoder. Samples the multiplexed segment and digit-enable lines of a 4-digit scanned display, filters out scan transitions, and decodes each stable pattern back to a hex nibble. Once all four digits are captured, it assembles a 16-bit frame and presents it on a valid/ready handshake. Used as a checker or loopback monitor that sits beside the display driver.

## Interface
- STABLE_CYCLES, 4: consecutive identical samples needed before a digit is captured; legal range 1–15.
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- seg  in  7  segment lines, active-high; seg[6..0] = a (top), b (upper-left), c (lower-left), d (bottom), e (lower-right), f (upper-right), g (middle)
- an  in  4  digit enables, active-high, one-hot; an[i] selects digit i, where digit 3 is most significant
- out_value  out  16  decoded frame; nibble i holds digit i
- out_err  out  4  per-digit flag: the captured pattern was not a legal code
- out_blank  out  4  per-digit flag: the digit was captured blank (see Configuration)
- out_valid  out  1  frame available
- out_ready  in  1  consumer accepts the frame

## Operation
- Legal codes (seg hex → nibble): 7E→0, 06→1, 5B→2, 4F→3, 27→4, 6D→5, 7D→6, 46→7, 7F→8, 6F→9, 77→A, 3D→B, 78→C, 1F→D, 79→E, 71→F. Any other code is illegal: the nibble is 0 and out_err[i] is set to 1.
- Stability filter:
  - A register holds the previous {an, seg} sample, and a 4-bit counter tracks how long it has been unchanged.
  - Any change in the sample, or an that is not one-hot (0000 or multiple bits set), reloads the counter to 1 and disarms capture.
  - When the counter reaches STABLE_CYCLES with a one-hot an, the digit is captured exactly once. No recapture happens until the sample changes.
- The FSM has two states: COLLECT and PRESENT.
  - COLLECT: each capture writes nibble i, err[i] and blank[i], and sets mask[i]. Recapturing a digit already in the mask overwrites its slot. When the mask reaches 1111, the FSM moves to PRESENT.
  - PRESENT: out_valid = 1 and all outputs are frozen. Captures are ignored, but the filter keeps running. When out_valid && out_ready, the FSM clears the mask and returns to COLLECT.
- On reset: state = COLLECT, mask = 0, counter = 0, the sample register holds 0. out_value = 0, out_err = 0, out_blank = 0, out_valid = 0.
- Reset asserted mid-frame or mid-PRESENT discards the frame immediately and asynchronously.

## Timing
- A digit held steady from cycle t is captured at the rising edge that ends cycle t+STABLE_CYCLES−1.
- out_valid rises one cycle after the edge that captures the 4th distinct digit.
- Handshake: the transfer happens on the edge where out_valid && out_ready are both 1. out_valid falls the next cycle; the earliest next capture is in that same cycle.
- out_ready is ignored while out_valid = 0. Holding out_ready = 1 permanently gives one-cycle PRESENT dwells.
- A capture on the same edge as the accepting handshake is dropped.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- SEG7_BLANK_EN:
  - Defined: seg = 00 with a one-hot an is legal. It captures nibble 0 with out_blank[i] = 1 and out_err[i] = 0.
  - Undefined: seg = 00 is illegal (out_err[i] = 1), and out_blank is tied to 0000.

## Test plan
- Reset value: rst_n low, any inputs → all outputs 0. Release with an = 0000 → out_valid stays 0 indefinitely.
- Basic frame with STABLE_CYCLES = 4: drive an = 1000/5B, 0100/7F, 0010/78, 0001/71, each held 4 cycles → out_value = 0x28CF, out_err = 0, out_valid 1 cycle after the last capture. out_ready = 1 → out_valid drops the next cycle.
- Glitch filter: hold 0001/06 for 3 cycles, then 0001/07 for 4 cycles, then complete the other digits with legal codes → digit 0 has out_err[0] = 1 and nibble 0. The 3-cycle 06 dwell is never captured.
- Non-one-hot and overwrite: an = 0011 held for 10 cycles → no capture. Then digit 2 = 4F, then digit 2 = 6F, then the remaining digits → nibble 2 = 9.
- Backpressure: frame 0x1234 completes with out_ready = 0 for 20 cycles while a different scan runs → out_value stays 0x1234. After acceptance, the next frame reflects only captures made after the handshake.
- Macro: seg = 00 on digit 1 → with SEG7_BLANK_EN, out_blank = 0010 and out_err = 0000. Without it, out_err = 0010 and out_blank = 0000. Assert rst_n mid-frame → mask cleared and no partial frame is ever presented.
